// File: rtl/dds_wave_gen.sv
// dds_wave_gen: direct-digital-synthesis waveform generator with line/frame framing.
//
// Ports:
//   clkin      in   pixel clock, sole clock
//   rst_n      in   synchronous active-low reset
//   en         in   advance enable; low freezes accumulator, counters, pipe, outputs
//   mode       in   2-bit wave select: 0 sine, 1 square, 2 triangle, 3 sawtooth
//   ftw        in   frequency tuning word (PHASE_W)
//   phase_ofs  in   phase offset added after the accumulator (PHASE_W)
//   cfg_ld     in   strobe: capture ftw/phase_ofs/mode into pending registers
//   sin_x      out  sample, offset binary (OUT_W); mid-scale outside active cycles
//   hsync      out  high during active cycles of an active line
//   vsync      out  high during active lines of a frame
//
// Pipeline: stage 1 phase add, stage 2 quarter-wave ROM read, stage 3 wave select.
// Sync flags travel with the samples, so sin_x/hsync/vsync are exactly aligned.

module dds_wave_gen #(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned LUT_AW   = 8,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BLANK  = 45
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic               cfg_ld,
  output logic [OUT_W-1:0]   sin_x,
  output logic               hsync,
  output logic               vsync
);

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam int unsigned H_TOT = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOT = V_ACTIVE + V_BLANK;
  localparam int unsigned HC_W  = $clog2(H_TOT);
  localparam int unsigned VC_W  = $clog2(V_TOT);
  // Only the top phase bits are needed past stage 1: quadrant + ROM index, or
  // the OUT_W+1 bits used by triangle/sawtooth, whichever is wider.
  localparam int unsigned P1_W  = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
  localparam int unsigned ROM_N = 2 ** LUT_AW;
  localparam int unsigned AMP   = 2 ** (OUT_W - 1) - 1;
  localparam logic [OUT_W-1:0] MID = OUT_W'(2 ** (OUT_W - 1));
  localparam real PI = 3.14159265358979323846;

  // Quarter-wave sine ROM, sampled at bin centres.
  logic [OUT_W-2:0] w_rom [ROM_N];

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam real ANG = 2.0 * PI * (real'(k) + 0.5) / real'(2 ** (LUT_AW + 2));
    localparam int unsigned VAL = $rtoi(real'(AMP) * $sin(ANG) + 0.5);
    assign w_rom[k] = (OUT_W-1)'(VAL);
  end

  // Configuration
  logic [PHASE_W-1:0] r_ftw_pend, r_ofs_pend, r_ftw_act, r_ofs_act;
  wave_e              r_mode_pend, r_mode_act;
  logic [PHASE_W-1:0] w_ftw_eff, w_ofs_eff;
  wave_e              w_mode_eff;
  logic               w_line_start;

  // Framing and accumulator
  logic [HC_W-1:0]    r_h_cnt;
  logic [VC_W-1:0]    r_v_cnt;
  logic               w_h_last, w_v_last, w_hs_raw, w_vs_raw;
  logic [PHASE_W-1:0] r_acc;

  // Pipeline
  logic [P1_W-1:0]    w_p1;
  logic [P1_W-1:0]    r_p1;
  wave_e              r_mode1, r_mode2;
  logic               r_hs1, r_vs1, r_hs2, r_vs2, r_hs3, r_vs3;
  logic [LUT_AW-1:0]  w_idx, w_addr;
  logic [OUT_W-2:0]   r_lut;
  logic [OUT_W:0]     r_p2;
  logic [OUT_W-1:0]   w_wave, r_sin;

  assign w_line_start = en && (r_h_cnt == '0);

  // The line-start commit is bypassed straight into this cycle's accumulator
  // step and phase add, so a new config shows up exactly 3 cycles after h_cnt=0.
  always_comb begin
    w_ftw_eff  = r_ftw_act;
    w_ofs_eff  = r_ofs_act;
    w_mode_eff = r_mode_act;
    if (w_line_start) begin
      if (cfg_ld) begin
        w_ftw_eff  = ftw;
        w_ofs_eff  = phase_ofs;
        w_mode_eff = wave_e'(mode);
      end else begin
        w_ftw_eff  = r_ftw_pend;
        w_ofs_eff  = r_ofs_pend;
        w_mode_eff = r_mode_pend;
      end
    end
  end

  // Pending registers load regardless of en.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_ftw_pend  <= '0;
      r_ofs_pend  <= '0;
      r_mode_pend <= WAVE_SINE;
    end else if (cfg_ld) begin
      r_ftw_pend  <= ftw;
      r_ofs_pend  <= phase_ofs;
      r_mode_pend <= wave_e'(mode);
    end
  end

  assign w_h_last = (r_h_cnt == HC_W'(H_TOT - 1));
  assign w_v_last = (r_v_cnt == VC_W'(V_TOT - 1));
  assign w_vs_raw = (r_v_cnt < VC_W'(V_ACTIVE));
  assign w_hs_raw = (r_h_cnt < HC_W'(H_ACTIVE)) && w_vs_raw;

  assign w_p1   = P1_W'((r_acc + w_ofs_eff) >> (PHASE_W - P1_W));
  assign w_idx  = r_p1[P1_W-3 -: LUT_AW];
  // Odd quadrants read the table mirrored.
  assign w_addr = r_p1[P1_W-2] ? ~w_idx : w_idx;

  always_comb begin
    w_wave = MID;
    unique case (r_mode2)
      WAVE_SINE:   w_wave = r_p2[OUT_W] ? (MID - {1'b0, r_lut}) : (MID + {1'b0, r_lut});
      WAVE_SQUARE: w_wave = r_p2[OUT_W] ? OUT_W'(1) : '1;
      WAVE_TRI:    w_wave = r_p2[OUT_W] ? ~r_p2[OUT_W-1:0] : r_p2[OUT_W-1:0];
      WAVE_SAW:    w_wave = r_p2[OUT_W -: OUT_W];
      default:     w_wave = MID;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_ftw_act  <= '0;
      r_ofs_act  <= '0;
      r_mode_act <= WAVE_SINE;
      r_acc      <= '0;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_p1       <= '0;
      r_mode1    <= WAVE_SINE;
      r_hs1      <= 1'b0;
      r_vs1      <= 1'b0;
      r_lut      <= '0;
      r_p2       <= '0;
      r_mode2    <= WAVE_SINE;
      r_hs2      <= 1'b0;
      r_vs2      <= 1'b0;
      r_sin      <= MID;
      r_hs3      <= 1'b0;
      r_vs3      <= 1'b0;
    end else if (en) begin
      if (w_line_start) begin
        r_ftw_act  <= w_ftw_eff;
        r_ofs_act  <= w_ofs_eff;
        r_mode_act <= w_mode_eff;
      end
      r_acc <= r_acc + w_ftw_eff;

      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end

      r_p1    <= w_p1;
      r_mode1 <= w_mode_eff;
      r_hs1   <= w_hs_raw;
      r_vs1   <= w_vs_raw;

      r_lut   <= w_rom[w_addr];
      r_p2    <= r_p1[P1_W-1 -: OUT_W+1];
      r_mode2 <= r_mode1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;

      r_sin   <= r_hs2 ? w_wave : MID;
      r_hs3   <= r_hs2;
      r_vs3   <= r_vs2;
    end
  end

  assign sin_x = r_sin;
  assign hsync = r_hs3;
  assign vsync = r_vs3;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Testbench for dds_wave_gen: directed sequences plus randomized config/en/reset
// traffic, all outputs compared every cycle against a behavioural model.

module tb_dds_wave_gen;

  localparam int PW  = 24;
  localparam int AW  = 8;
  localparam int OW  = 12;
  localparam int HA  = 24;
  localparam int HB  = 6;
  localparam int VA  = 3;
  localparam int VB  = 2;
  localparam int HT  = HA + HB;
  localparam int VT  = VA + VB;
  localparam int MID = 2 ** (OW - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [PW-1:0] ftw;
  logic [PW-1:0] phase_ofs;
  logic          cfg_ld;
  logic [OW-1:0] sin_x;
  logic          hsync;
  logic          vsync;

  dds_wave_gen #(
    .PHASE_W (PW),
    .LUT_AW  (AW),
    .OUT_W   (OW),
    .H_ACTIVE(HA),
    .H_BLANK (HB),
    .V_ACTIVE(VA),
    .V_BLANK (VB)
  ) u_dut (
    .clkin    (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .ftw      (ftw),
    .phase_ofs(phase_ofs),
    .cfg_ld   (cfg_ld),
    .sin_x    (sin_x),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int            lut_tab [2 ** AW];
  logic [PW-1:0] m_acc;
  int            m_h, m_v;
  logic [PW-1:0] m_ftw_a, m_ofs_a, m_ftw_p, m_ofs_p;
  int            m_mode_a, m_mode_p;
  int            q_s[$];
  int            q_hs[$];
  int            q_vs[$];
  int            exp_s, exp_hs, exp_vs;

  function automatic int ref_wave(input int m, input logic [PW-1:0] p);
    int ph, quad, idx, k, t;
    ph   = int'(p);
    quad = ph >> (PW - 2);
    case (m)
      0: begin
        idx = (ph >> (PW - 2 - AW)) % (2 ** AW);
        k   = (quad % 2 == 1) ? (2 ** AW - 1 - idx) : idx;
        return (quad < 2) ? MID + lut_tab[k] : MID - lut_tab[k];
      end
      1: return (quad >= 2) ? 1 : 2 ** OW - 1;
      2: begin
        t = (ph >> (PW - 1 - OW)) % (2 ** OW);
        return (quad >= 2) ? 2 ** OW - 1 - t : t;
      end
      default: return ph >> (PW - OW);
    endcase
  endfunction

  task automatic model_reset();
    m_acc = '0; m_h = 0; m_v = 0;
    m_ftw_a = '0; m_ofs_a = '0; m_mode_a = 0;
    m_ftw_p = '0; m_ofs_p = '0; m_mode_p = 0;
    q_s  = '{MID, MID};
    q_hs = '{0, 0};
    q_vs = '{0, 0};
    exp_s = MID; exp_hs = 0; exp_vs = 0;
  endtask

  // Advance model by one clock with current inputs, clock the DUT, compare.
  task automatic tick();
    logic [PW-1:0] f_eff, o_eff, p;
    int            md_eff, hs, vs;
    if (!rst_n) begin
      model_reset();
    end else begin
      f_eff = m_ftw_a; o_eff = m_ofs_a; md_eff = m_mode_a;
      if (en && m_h == 0) begin
        if (cfg_ld) begin
          f_eff = ftw; o_eff = phase_ofs; md_eff = int'(mode);
        end else begin
          f_eff = m_ftw_p; o_eff = m_ofs_p; md_eff = m_mode_p;
        end
      end
      if (cfg_ld) begin
        m_ftw_p = ftw; m_ofs_p = phase_ofs; m_mode_p = int'(mode);
      end
      if (en) begin
        hs = (m_h < HA && m_v < VA) ? 1 : 0;
        vs = (m_v < VA) ? 1 : 0;
        p  = m_acc + o_eff;
        q_s.push_back(hs ? ref_wave(md_eff, p) : MID);
        q_hs.push_back(hs);
        q_vs.push_back(vs);
        exp_s  = q_s.pop_front();
        exp_hs = q_hs.pop_front();
        exp_vs = q_vs.pop_front();
        if (m_h == 0) begin
          m_ftw_a = f_eff; m_ofs_a = o_eff; m_mode_a = md_eff;
        end
        m_acc = m_acc + f_eff;
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("sin_x", int'(sin_x), exp_s);
    chk("hsync", int'(hsync), exp_hs);
    chk("vsync", int'(vsync), exp_vs);
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    int budget;
    budget = 0;
    while (!(m_h == h && (v < 0 || m_v == v)) && budget < 2000) begin
      tick();
      budget++;
    end
    if (budget >= 2000) chk(tag, 0, 1);
  endtask

  initial begin
    for (int k = 0; k < 2 ** AW; k++)
      lut_tab[k] = $rtoi(real'(MID - 1) * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5) /
                   real'(2 ** (AW + 2))) + 0.5);
    model_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; ftw = '0; phase_ofs = '0; cfg_ld = 1'b0;
    tick();
    tick();
    chk("rst_sin", int'(sin_x), 2048);
    chk("rst_hs", int'(hsync), 0);
    chk("rst_vs", int'(vsync), 0);

    // Sine quadrature: load on the first line-start cycle after reset.
    rst_n = 1'b1; cfg_ld = 1'b1; ftw = PW'(1 << 20); phase_ofs = '0; mode = 2'd0;
    tick();
    cfg_ld = 1'b0;
    for (int n = 2; n <= 16; n++) begin
      tick();
      case (n)
        3:  chk("quad_p0", int'(sin_x), 2054);
        7:  chk("quad_p90", int'(sin_x), 4095);
        11: chk("quad_p180", int'(sin_x), 2042);
        15: chk("quad_p270", int'(sin_x), 1);
        default: ;
      endcase
    end

    // Deferred load mid-line.
    run_to(10, -1, "tmo_defer");
    cfg_ld = 1'b1; ftw = PW'(1 << 21);
    tick();
    cfg_ld = 1'b0;
    for (int n = 0; n < 2 * HT; n++) tick();

    // Square, triangle, sawtooth at ftw = 2^20.
    for (int m = 1; m <= 3; m++) begin
      cfg_ld = 1'b1; ftw = PW'(1 << 20); phase_ofs = '0; mode = 2'(m);
      tick();
      cfg_ld = 1'b0;
      for (int n = 0; n < 2 * HT; n++) tick();
    end

    // en freeze mid-line.
    run_to(5, -1, "tmo_en");
    en = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    en = 1'b1;
    for (int n = 0; n < HT; n++) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      en     = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 499) != 0);
      cfg_ld = ($urandom_range(0, 19) == 0);
      if (cfg_ld) begin
        ftw       = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 1 << 21)) : PW'($urandom);
        phase_ofs = PW'($urandom);
        mode      = 2'($urandom_range(0, 3));
      end
      tick();
    end
    rst_n = 1'b1; en = 1'b1; cfg_ld = 1'b0;

    // Reset mid-frame at v_cnt=1, h_cnt=3.
    cfg_ld = 1'b1; ftw = PW'(1 << 20); phase_ofs = PW'(12345); mode = 2'd3;
    tick();
    cfg_ld = 1'b0;
    run_to(3, 1, "tmo_rst");
    rst_n = 1'b0;
    tick();
    chk("mrst_sin", int'(sin_x), 2048);
    chk("mrst_hs", int'(hsync), 0);
    chk("mrst_vs", int'(vsync), 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mrst_sine0", int'(sin_x), 2054);
    chk("mrst_hs_up", int'(hsync), 1);
    for (int n = 0; n < VT * HT; n++) tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
